// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, round constants, IV, FSM states
// and the Maj/Sigma helpers used by the round datapath.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ROUNDS = 64;
  localparam logic [5:0]  LAST_ROUND = 6'd63;

  typedef logic [WORD_W-1:0] word_t;

  // Packed so that a sits in [255:224], matching the H0..H7 packing of the bus.
  typedef struct packed {
    word_t a, b, c, d, e, f, g, h;
  } work_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam word_t K [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Feed-forward of the chaining value into the compressed state, word by word.
  function automatic work_t add_state(input work_t x, input work_t y);
    work_t s;
    s.a = x.a + y.a;
    s.b = x.b + y.b;
    s.c = x.c + y.c;
    s.d = x.d + y.d;
    s.e = x.e + y.e;
    s.f = x.f + y.f;
    s.g = x.g + y.g;
    s.h = x.h + y.h;
    return s;
  endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// Message-word handshake between the scheduler (master) and the compression core (slave).
interface sha256_compress_core_if;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;

  modport master (output w_data, output w_valid, input w_ready);
  modport slave  (input w_data, input w_valid, output w_ready);
endinterface

// File: rtl/sha256_round_func.sv
// Combinational SHA-256 round: next a..h from current a..h, K_t and W_t.
module ch_func
  import sha256_pkg::*;
(
  input  word_t x,
  input  word_t y,
  input  word_t z,
  output word_t ch
);
  assign ch = (x & y) ^ (~x & z);
endmodule

module sha256_round_func
  import sha256_pkg::*;
(
  input  work_t cur,
  input  word_t k_t,
  input  word_t w_t,
  output work_t nxt
);
  word_t ch, t1, t2;

  ch_func u_ch (.x(cur.e), .y(cur.f), .z(cur.g), .ch(ch));

  assign t1  = cur.h + big_sigma1(cur.e) + ch + k_t + w_t;
  assign t2  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
  assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                 e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per accepted W_t, then the
// chaining-value feed-forward into hash_out with a one-cycle done pulse.
module sha256_compress_core
  import sha256_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [255:0]            init_hash,
  sha256_compress_core_if.slave   w_bus,
  output logic                    busy,
  output logic                    done,
  output logic [255:0]            hash_out
);
  state_t     state, state_nxt;
  logic [5:0] t;
  work_t      h_reg, work, work_nxt;
  word_t      k_t;
  logic       w_ready_q;
  logic       fire;

  assign fire          = (state == ST_ROUND) && w_ready_q && w_bus.w_valid;
  assign busy          = (state != ST_IDLE);
  assign w_bus.w_ready = w_ready_q;

  // Constant ROM indexed by the round counter.
  assign k_t = K[t];

  sha256_round_func u_round (.cur(work), .k_t(k_t), .w_t(w_bus.w_data), .nxt(work_nxt));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ROUND;
      ST_ROUND: if (fire && (t == LAST_ROUND)) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t     <= '0;
      h_reg <= '0;
      work  <= '0;
    end else if ((state == ST_IDLE) && start) begin
      t     <= '0;
      h_reg <= init_hash;
      work  <= init_hash;
    end else if (fire) begin
      work <= work_nxt;
      // Holding at 63 keeps the counter from wrapping; FINAL is the only exit.
      if (t != LAST_ROUND) t <= t + 6'd1;
    end
  end

  // w_ready is registered from the next state, so it equals (state == ROUND).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ready_q <= 1'b0;
      done      <= 1'b0;
      hash_out  <= '0;
    end else begin
      w_ready_q <= (state_nxt == ST_ROUND);
      done      <= (state == ST_FINAL);
      if (state == ST_FINAL) hash_out <= add_state(h_reg, work);
    end
  end

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core: known-answer blocks, stalls,
// ignored stimulus, chained blocks and mid-block reset.
module tb_sha256_compress_core;
  import sha256_pkg::*;

  logic         clk, rst_n, start, busy, done;
  logic [255:0] init_hash, hash_out;
  int           n_cmp, n_bad;
  word_t        sched [64];

  sha256_compress_core_if w_bus ();

  sha256_compress_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_hash(init_hash),
    .w_bus(w_bus), .busy(busy), .done(done), .hash_out(hash_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [511:0] blk;
    logic [255:0] iv;
    logic [255:0] exp;
    bit           gaps;
    bit           noise;
  } vec_t;

  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_TWO_1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic word_t rr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference message schedule (the scheduler's job, not the DUT's).
  task automatic make_sched(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      sched[i] = (rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10)) + sched[i-7] +
                 (rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3)) + sched[i-16];
  endtask

  // Must be called at a negedge. Latency counts edges from the start edge
  // (edge 1) through the edge that raises done.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] iv,
                           input bit gaps, input bit noise,
                           output logic [255:0] digest, output int edges, output int stalls,
                           output bit ctrl_ok, output bit hold_ok, output bit timed_out);
    int acc;
    bit hs;
    logic [255:0] held;
    make_sched(blk);
    held = hash_out; acc = 0; stalls = 0; ctrl_ok = 1; hold_ok = 1; timed_out = 0;
    start = 1'b1; init_hash = iv;
    w_bus.w_valid = noise; w_bus.w_data = 32'hbad0bad0;
    @(posedge clk); edges = 1;
    while (1) begin
      @(negedge clk);
      if (done === 1'b1) break;
      if (edges >= 400) begin timed_out = 1; break; end
      if (w_bus.w_ready !== (acc < 64) || busy !== 1'b1) ctrl_ok = 0;
      if (hash_out !== held) hold_ok = 0;
      if (acc < 64) begin
        if (gaps && $urandom_range(0, 1) == 0) begin
          w_bus.w_valid = 1'b0; w_bus.w_data = $urandom; stalls++;
        end else begin
          w_bus.w_valid = 1'b1; w_bus.w_data = sched[acc];
        end
      end else begin
        w_bus.w_valid = noise; w_bus.w_data = 32'hbad0bad0;
      end
      start = noise; init_hash = noise ? ~iv : iv;
      hs = w_bus.w_valid && w_bus.w_ready;
      @(posedge clk); edges++;
      if (hs) acc++;
    end
    start = 1'b0; w_bus.w_valid = 1'b0;
    digest = hash_out;
  endtask

  vec_t         vecs [4];
  logic [255:0] dig, dig1;
  int           edges, stalls, seen;
  bit           ctrl_ok, hold_ok, tmo;

  initial begin
    n_cmp = 0; n_bad = 0;
    vecs[0] = '{blk: BLK_EMPTY, iv: SHA256_IV, exp: DIG_EMPTY, gaps: 1'b0, noise: 1'b0};
    vecs[1] = '{blk: BLK_ABC,   iv: SHA256_IV, exp: DIG_ABC,   gaps: 1'b0, noise: 1'b0};
    vecs[2] = '{blk: BLK_ABC,   iv: SHA256_IV, exp: DIG_ABC,   gaps: 1'b1, noise: 1'b0};
    vecs[3] = '{blk: BLK_ABC,   iv: SHA256_IV, exp: DIG_ABC,   gaps: 1'b0, noise: 1'b1};

    rst_n = 1'b0; start = 1'b0; init_hash = '0; w_bus.w_valid = 1'b0; w_bus.w_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_w_ready", w_bus.w_ready, 0);
    check("reset_hash_out", hash_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      repeat (2) @(negedge clk);
      run_block(vecs[i].blk, vecs[i].iv, vecs[i].gaps, vecs[i].noise, dig, edges, stalls, ctrl_ok, hold_ok, tmo);
      check($sformatf("vec%0d_timeout", i), tmo, 0);
      check($sformatf("vec%0d_digest", i), dig, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), edges, 66 + stalls);
      check($sformatf("vec%0d_ready_window", i), ctrl_ok, 1);
      check($sformatf("vec%0d_hash_hold", i), hold_ok, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {done, busy}, 2'b00);
    end

    // Two-block message, second start issued in the done cycle of the first.
    repeat (2) @(negedge clk);
    run_block(BLK_TWO_1, SHA256_IV, 1'b0, 1'b0, dig1, edges, stalls, ctrl_ok, hold_ok, tmo);
    check("b2b_first_timeout", tmo, 0);
    run_block(BLK_TWO_2, dig1, 1'b0, 1'b0, dig, edges, stalls, ctrl_ok, hold_ok, tmo);
    check("b2b_digest", dig, DIG_TWO);
    check("b2b_latency", edges, 66);
    check("b2b_hash_hold", hold_ok, 1);
    check("b2b_ready_window", ctrl_ok, 1);

    // Reset after 30 rounds of "abc", then restart the block.
    @(negedge clk);
    make_sched(BLK_ABC);
    start = 1'b1; init_hash = SHA256_IV;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      w_bus.w_valid = 1'b1; w_bus.w_data = sched[i];
      @(negedge clk);
    end
    rst_n = 1'b0; w_bus.w_valid = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_w_ready", w_bus.w_ready, 0);
    check("midreset_done", done, 0);
    check("midreset_hash_out", hash_out, 0);
    rst_n = 1'b1;
    seen = 0;
    w_bus.w_valid = 1'b1; w_bus.w_data = 32'h12345678;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    w_bus.w_valid = 1'b0;
    check("midreset_no_done", seen, 0);
    run_block(BLK_ABC, SHA256_IV, 1'b0, 1'b0, dig, edges, stalls, ctrl_ok, hold_ok, tmo);
    check("restart_digest", dig, DIG_ABC);
    check("restart_latency", edges, 66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
